// File: rtl/arith_pkg.sv
// Shared arithmetic package for the sequential multiply/divide datapath.
//
// Purpose:
//   - State encoding for the shift-and-add multiplier FSM. The planned
//     restoring divider reuses the same IDLE/RUN/DONE encoding.
//   - The handshake convention used on every valid/ready interface in this
//     datapath: a transfer happens at the rising clk edge when valid and
//     ready are both high.
//
// No ports; compile this package before any module that imports it.
package arith_pkg;

  // Raw state codes. They stay visible as plain constants so older code
  // that compares against literal state values still works.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } mul_state_t;

  // A valid/ready pair transfers one item at the clock edge where both
  // signals are high.
  function automatic logic xfer(input logic valid, input logic ready);
    return valid && ready;
  endfunction

endpackage

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH -> 2*WIDTH multiplier.
//
// Radix-2 shift-and-add: one multiplier bit is consumed per clock. A single
// (WIDTH+1)-bit adder is shared by all iterations.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (priority over all inputs)
//   in_valid   operand pair presented
//   in_ready   block can accept operands (high only in IDLE)
//   mcand      multiplicand, sampled when in_valid && in_ready
//   mplier     multiplier, sampled when in_valid && in_ready
//   out_valid  product available (high only in DONE)
//   out_ready  consumer accepts the product
//   product    mcand * mplier, held stable while out_valid is high
//
// Timing: after acceptance the block spends exactly WIDTH cycles in RUN and
// then presents the result in DONE. A zero operand skips RUN entirely, so
// the result appears in the cycle right after acceptance. DONE always
// returns to IDLE before the next acceptance, so there is no same-cycle
// accept-after-result.
module shift_add_multiplier
  import arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  // Large enough to hold WIDTH itself; derived, never overridden.
  localparam int CNT_W = $clog2(WIDTH) + 1;

  mul_state_t         state_reg;
  logic [WIDTH-1:0]   mcand_reg;
  logic [WIDTH-1:0]   acc_hi_reg;
  logic [WIDTH-1:0]   acc_lo_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [2*WIDTH-1:0] product_reg;

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   acc_hi_next;
  logic [WIDTH-1:0]   acc_lo_next;

  // Conditional add of the multiplicand into the upper half. The adder is
  // one bit wider than the operands so the carry survives.
  assign sum = {1'b0, acc_hi_reg} +
               (acc_lo_reg[0] ? {1'b0, mcand_reg} : {(WIDTH+1){1'b0}});

  // Shift the (2*WIDTH+1)-bit value {sum, acc_lo} right by one. The carry
  // lands in the top of acc_hi and sum[0] moves into the top of acc_lo,
  // while the consumed multiplier bit falls off the bottom. acc_lo starts
  // out holding the multiplier and is replaced bit by bit by low product
  // bits.
  assign acc_hi_next = sum[WIDTH:1];
  assign acc_lo_next = {sum[0], acc_lo_reg[WIDTH-1:1]};

  // Handshake outputs come straight from the registered state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    if (state_reg == IDLE) in_ready  = 1'b1;
    if (state_reg == DONE) out_valid = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Any operation in flight is abandoned; no result is produced.
      state_reg   <= IDLE;
      mcand_reg   <= '0;
      acc_hi_reg  <= '0;
      acc_lo_reg  <= '0;
      count_reg   <= '0;
      product_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (xfer(in_valid, in_ready)) begin
            mcand_reg  <= mcand;
            acc_hi_reg <= '0;
            acc_lo_reg <= mplier;
            count_reg  <= CNT_W'(WIDTH);
            // With a zero operand the product is known at once, so the
            // RUN iterations are skipped.
            if (mcand == '0 || mplier == '0) begin
              product_reg <= '0;
              state_reg   <= DONE;
            end else begin
              state_reg <= RUN;
            end
          end
        end

        RUN: begin
          acc_hi_reg <= acc_hi_next;
          acc_lo_reg <= acc_lo_next;
          count_reg  <= count_reg - CNT_W'(1);
          // count_reg == 1 marks the last multiplier bit. The product is
          // taken from the next-state values so it is ready on entry to
          // DONE.
          if (count_reg == CNT_W'(1)) begin
            product_reg <= {acc_hi_next, acc_lo_next};
            state_reg   <= DONE;
          end
        end

        DONE: begin
          // product_reg is left untouched here; it holds the result until
          // the next completion.
          if (xfer(out_valid, out_ready)) begin
            state_reg <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign product = product_reg;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier.
// Two instances: WIDTH=4 (main tests, exhaustive sweep) and WIDTH=8 (wide
// carry and max-operand cases). Latency is counted in clock edges,
// including the edge that accepts the operands: 1 for a zero operand and
// WIDTH+1 otherwise.
module tb_shift_add_multiplier;

  logic       clk = 1'b0;
  logic       rst;

  // WIDTH = 4 instance
  logic       in_valid;
  logic       in_ready;
  logic [3:0] mcand;
  logic [3:0] mplier;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] product;

  // WIDTH = 8 instance
  logic        in_valid8;
  logic        in_ready8;
  logic [7:0]  mcand8;
  logic [7:0]  mplier8;
  logic        out_valid8;
  logic        out_ready8;
  logic [15:0] product8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_add_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .mcand(mcand), .mplier(mplier),
    .out_valid(out_valid), .out_ready(out_ready),
    .product(product)
  );

  shift_add_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .mcand(mcand8), .mplier(mplier8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .product(product8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One WIDTH=4 transaction. When release_now is set, out_ready is assumed
  // high and the transfer back to IDLE is also checked.
  task automatic mul4(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp,
                      input int exp_lat, input logic release_now);
    int w;
    int lat;
    w = 0;
    while (!in_ready && w < 40) begin
      @(posedge clk); #1; w++;
    end
    in_valid = 1'b1; mcand = a; mplier = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    mcand = 4'($urandom); mplier = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check($sformatf("lat %0dx%0d", a, b), lat, exp_lat);
    check($sformatf("prod %0dx%0d", a, b), {24'd0, product}, {24'd0, exp});
    if (release_now) begin
      @(posedge clk); #1;
      check($sformatf("ovalid_drop %0dx%0d", a, b), {31'd0, out_valid}, 32'd0);
      check($sformatf("iready_back %0dx%0d", a, b), {31'd0, in_ready}, 32'd1);
    end
    $display("mul4 %0d x %0d -> %0d (lat %0d)", a, b, product, lat);
  endtask

  task automatic mul8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                      input int exp_lat);
    int lat;
    in_valid8 = 1'b1; mcand8 = a; mplier8 = b;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    mcand8 = 8'($urandom); mplier8 = 8'($urandom);
    lat = 1;
    while (!out_valid8 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check($sformatf("lat8 %0dx%0d", a, b), lat, exp_lat);
    check($sformatf("prod8 %0dx%0d", a, b), {16'd0, product8}, {16'd0, exp});
    @(posedge clk); #1;
    check($sformatf("iready8_back %0dx%0d", a, b), {31'd0, in_ready8}, 32'd1);
    $display("mul8 %0d x %0d -> %0d (lat %0d)", a, b, product8, lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; mcand = '0; mplier = '0; out_ready = 1'b1;
    in_valid8 = 1'b0; mcand8 = '0; mplier8 = '0; out_ready8 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_iready", {31'd0, in_ready}, 32'd1);
    check("rst_ovalid", {31'd0, out_valid}, 32'd0);
    check("rst_product", {24'd0, product}, 32'd0);
    check("rst_iready8", {31'd0, in_ready8}, 32'd1);

    // Basic and carry cases
    mul4(4'd13, 4'd11, 8'd143, 5, 1'b1);
    mul4(4'd15, 4'd15, 8'd225, 5, 1'b1);

    // Zero operands: one-edge latency
    mul4(4'd0, 4'd9, 8'd0, 1, 1'b1);
    mul4(4'd7, 4'd0, 8'd0, 1, 1'b1);

    // Back-pressure: result held, new operands ignored
    out_ready = 1'b0;
    mul4(4'd13, 4'd11, 8'd143, 5, 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      mcand = 4'(i); mplier = 4'(15 - i);
      @(posedge clk); #1;
      check("hold_prod", {24'd0, product}, 32'd143);
      check("hold_ovalid", {31'd0, out_valid}, 32'd1);
      check("hold_iready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("rel_ovalid", {31'd0, out_valid}, 32'd0);
    check("rel_iready", {31'd0, in_ready}, 32'd1);
    $display("hold: product held at %0d for 10 cycles, released", product);

    // Reset on the second RUN cycle of 6 x 7
    in_valid = 1'b1; mcand = 4'd6; mplier = 4'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_iready", {31'd0, in_ready}, 32'd1);
    check("midrst_ovalid", {31'd0, out_valid}, 32'd0);
    check("midrst_product", {24'd0, product}, 32'd0);
    repeat (6) @(posedge clk);
    #1 check("midrst_no_result", {31'd0, out_valid}, 32'd0);
    $display("midrst: abandoned 6 x 7, in_ready %0d", in_ready);
    mul4(4'd6, 4'd7, 8'd42, 5, 1'b1);

    // WIDTH = 8
    mul8(8'd255, 8'd255, 16'd65025, 9);
    mul8(8'd200, 8'd3, 16'd600, 9);
    mul8(8'd0, 8'd200, 16'd0, 1);
    mul8(8'd1, 8'd255, 16'd255, 9);

    // Exhaustive WIDTH = 4, back to back
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        mul4(4'(a), 4'(b), 8'(a * b), (a == 0 || b == 0) ? 1 : 5, 1'b1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
